// File: rtl/plic_gateway.sv
// Per-source interrupt gateway: 2-flop sync, then IDLE/PENDING/IN_SERVICE tracking feeding the PLIC target.
// Optional PLIC_EDGE_TRIG_EN adds per-source edge triggering with saturating edge counters.
module plic_gateway #(
  parameter int PLIC_SOURCE_COUNT   = 32,
  parameter int PLIC_SOURCE_WIDTH   = 6,
  parameter int PLIC_EDGE_CNT_WIDTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [PLIC_SOURCE_COUNT-1:0] irq_src_i,
`ifdef PLIC_EDGE_TRIG_EN
  input  logic [PLIC_SOURCE_COUNT-1:0] irq_edge_i,
`endif
  input  logic                         claim_req_i,
  input  logic [PLIC_SOURCE_WIDTH-1:0] claim_idx_i,
  input  logic                         complete_req_i,
  input  logic [PLIC_SOURCE_WIDTH-1:0] complete_idx_i,
  output logic [PLIC_SOURCE_COUNT-1:0] irq_pending_o
);

  localparam int N = PLIC_SOURCE_COUNT;

  if ((1 << PLIC_SOURCE_WIDTH) <= N) begin : g_bad_width
    $error("PLIC_SOURCE_WIDTH too small for PLIC_SOURCE_COUNT");
  end
  if (PLIC_EDGE_CNT_WIDTH < 1) begin : g_bad_cnt
    $error("PLIC_EDGE_CNT_WIDTH must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PENDING    = 2'd1,
    IN_SERVICE = 2'd2
  } state_e;

  logic [N-1:0] sync1_q;
  logic [N-1:0] s_q;
  state_e       st_q [N];
  state_e       st_d [N];
  logic [N-1:0] pend_d;
  logic [N-1:0] claim_hit;
  logic [N-1:0] cmpl_hit;
  logic [N-1:0] trig;

  // ID i+1 maps to source i; IDs 0 and out-of-range never match any source.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      claim_hit[i] = claim_req_i    && (claim_idx_i    == PLIC_SOURCE_WIDTH'(i + 1));
      cmpl_hit[i]  = complete_req_i && (complete_idx_i == PLIC_SOURCE_WIDTH'(i + 1));
    end
  end

`ifdef PLIC_EDGE_TRIG_EN
  logic [N-1:0]                   prev_q;
  logic [N-1:0]                   rise;
  logic [PLIC_EDGE_CNT_WIDTH-1:0] cnt_q [N];
  logic [PLIC_EDGE_CNT_WIDTH-1:0] cnt_d [N];

  assign rise = s_q & ~prev_q;
  assign trig = (irq_edge_i & rise) | (~irq_edge_i & s_q);
`else
  assign trig = s_q;
`endif

  always_comb begin
`ifdef PLIC_EDGE_TRIG_EN
    logic inc;
    logic rep;
`endif
    for (int i = 0; i < N; i++) begin
      st_d[i] = st_q[i];
`ifdef PLIC_EDGE_TRIG_EN
      cnt_d[i] = cnt_q[i];
      inc      = irq_edge_i[i] && rise[i] && (st_q[i] != IDLE);
      rep      = 1'b0;
`endif
      case (st_q[i])
        IDLE:       if (trig[i]) st_d[i] = PENDING;
        PENDING:    if (claim_hit[i]) st_d[i] = IN_SERVICE;
        IN_SERVICE: if (cmpl_hit[i]) begin
`ifdef PLIC_EDGE_TRIG_EN
          // An edge arriving with the complete is consumed directly as the re-pend.
          rep     = (cnt_q[i] != '0) || inc;
          st_d[i] = rep ? PENDING : IDLE;
`else
          st_d[i] = IDLE;
`endif
        end
        default:    st_d[i] = IDLE;
      endcase
`ifdef PLIC_EDGE_TRIG_EN
      if (inc && !rep && (cnt_q[i] != '1)) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end else if (rep && !inc) begin
        cnt_d[i] = cnt_q[i] - 1'b1;
      end
`endif
      pend_d[i] = (st_d[i] == PENDING);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q       <= '0;
      s_q           <= '0;
      irq_pending_o <= '0;
      st_q          <= '{default: IDLE};
`ifdef PLIC_EDGE_TRIG_EN
      prev_q        <= '0;
      cnt_q         <= '{default: '0};
`endif
    end else begin
      sync1_q       <= irq_src_i;
      s_q           <= sync1_q;
      irq_pending_o <= pend_d;
      st_q          <= st_d;
`ifdef PLIC_EDGE_TRIG_EN
      prev_q        <= s_q;
      cnt_q         <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_plic_gateway.sv
// Bench for plic_gateway: directed vector table, reset/edge sequences, and random traffic vs a reference model.
module tb_plic_gateway;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] src_v;
  logic        claim_v;
  logic [5:0]  claim_idx_v;
  logic        comp_v;
  logic [5:0]  comp_idx_v;
  logic [31:0] irq_pending_o;
`ifdef PLIC_EDGE_TRIG_EN
  logic [31:0] edge_v = '0;
`endif

  always #5 clk = ~clk;

  plic_gateway dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .irq_src_i     (src_v),
`ifdef PLIC_EDGE_TRIG_EN
    .irq_edge_i    (edge_v),
`endif
    .claim_req_i   (claim_v),
    .claim_idx_i   (claim_idx_v),
    .complete_req_i(comp_v),
    .complete_idx_i(comp_idx_v),
    .irq_pending_o (irq_pending_o)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] src;
    logic        clm;
    logic [5:0]  cidx;
    logic        cmp;
    logic [5:0]  pidx;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[$];

  // Reference: a request latches once the twice-delayed input is seen high
  // while the source is neither waiting nor in service.
  logic [31:0] m_pend, m_busy, m_d1, m_d2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 32; i++) begin
      if (m_pend[i]) begin
        if (claim_v && claim_idx_v == 6'(i + 1)) begin
          m_pend[i] = 1'b0;
          m_busy[i] = 1'b1;
        end
      end else if (m_busy[i]) begin
        if (comp_v && comp_idx_v == 6'(i + 1)) m_busy[i] = 1'b0;
      end else if (m_d2[i]) begin
        m_pend[i] = 1'b1;
      end
    end
    m_d2 = m_d1;
    m_d1 = src_v;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_strobes();
    claim_v = 1'b0; claim_idx_v = '0; comp_v = 1'b0; comp_idx_v = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    src_v = '0;
    idle_strobes();
    m_pend = '0; m_busy = '0; m_d1 = '0; m_d2 = '0;
    #1;
    check("async_reset", irq_pending_o, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic row(input logic [31:0] s, input logic c, input int ci,
                     input logic p, input int pi, input logic [31:0] e);
    vec_t v;
    v.src = s; v.clm = c; v.cidx = 6'(ci); v.cmp = p; v.pidx = 6'(pi); v.exp = e;
    tbl.push_back(v);
  endtask

  function automatic logic [5:0] pick(input logic [31:0] set);
    int st;
    st = $urandom_range(0, 31);
    for (int k = 0; k < 32; k++) begin
      if (set[(st + k) % 32]) return 6'((st + k) % 32 + 1);
    end
    return 6'($urandom_range(0, 40));
  endfunction

`ifdef PLIC_EDGE_TRIG_EN
  task automatic pulse2();
    src_v[2] = 1'b1;
    repeat (3) tick();
    src_v[2] = 1'b0;
    repeat (3) tick();
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b1;
    src_v = '0;
    idle_strobes();
    #2;

    // Level source 4: 3-edge latency, claim, re-pend two edges after complete.
    row(32'h000, 0, 0, 0, 0, 32'h000);
    row(32'h010, 0, 0, 0, 0, 32'h000);
    row(32'h010, 0, 0, 0, 0, 32'h000);
    row(32'h010, 0, 0, 0, 0, 32'h010);
    row(32'h010, 1, 5, 0, 0, 32'h000);
    row(32'h010, 0, 0, 0, 0, 32'h000);
    row(32'h010, 0, 0, 1, 5, 32'h000);
    row(32'h010, 0, 0, 0, 0, 32'h010);
    // Invalid IDs and complete-while-pending are ignored.
    row(32'h010, 1, 0, 0, 0, 32'h010);
    row(32'h010, 1, 33, 0, 0, 32'h010);
    row(32'h010, 0, 0, 1, 5, 32'h010);
    row(32'h010, 1, 63, 1, 0, 32'h010);
    // Same-cycle claim and complete on different and on identical IDs.
    row(32'h114, 0, 0, 0, 0, 32'h010);
    row(32'h114, 0, 0, 0, 0, 32'h010);
    row(32'h114, 0, 0, 0, 0, 32'h114);
    row(32'h114, 1, 9, 0, 0, 32'h014);
    row(32'h010, 0, 0, 0, 0, 32'h014);
    row(32'h010, 1, 3, 1, 9, 32'h010);
    row(32'h010, 0, 0, 0, 0, 32'h010);
    row(32'h010, 1, 5, 1, 3, 32'h000);
    row(32'h010, 1, 5, 1, 5, 32'h000);
    row(32'h010, 0, 0, 0, 0, 32'h010);
    row(32'h010, 1, 5, 1, 5, 32'h000);
    row(32'h000, 0, 0, 0, 0, 32'h000);
    row(32'h000, 0, 0, 1, 5, 32'h000);
    row(32'h000, 0, 0, 0, 0, 32'h000);
    // Short level pulse on source 0 stays latched until claimed.
    row(32'h001, 0, 0, 0, 0, 32'h000);
    row(32'h001, 0, 0, 0, 0, 32'h000);
    row(32'h001, 0, 0, 0, 0, 32'h001);
    row(32'h001, 0, 0, 0, 0, 32'h001);
    row(32'h000, 0, 0, 0, 0, 32'h001);
    row(32'h000, 0, 0, 0, 0, 32'h001);
    row(32'h000, 0, 0, 0, 0, 32'h001);
    row(32'h000, 1, 1, 0, 0, 32'h000);
    row(32'h000, 0, 0, 1, 1, 32'h000);
    row(32'h000, 0, 0, 0, 0, 32'h000);

    do_reset();
    for (int k = 0; k < tbl.size(); k++) begin
      src_v = tbl[k].src;
      claim_v = tbl[k].clm; claim_idx_v = tbl[k].cidx;
      comp_v = tbl[k].cmp;  comp_idx_v = tbl[k].pidx;
      tick();
      check($sformatf("vec%0d", k), irq_pending_o, tbl[k].exp);
    end
    idle_strobes();

    // Reset while source 0 is in service and source 2 pending.
    do_reset();
    src_v = 32'h5;
    repeat (3) tick();
    check("rst_pre_pend", irq_pending_o, 32'h5);
    claim_v = 1'b1; claim_idx_v = 6'd1;
    tick();
    idle_strobes();
    check("rst_pre_claim", irq_pending_o, 32'h4);
    do_reset();
    for (int k = 0; k < 4; k++) begin
      tick();
      check("rst_no_stale", irq_pending_o, 32'h0);
    end

    // Random traffic against the reference model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 1) == 0) src_v[$urandom_range(0, 31)] ^= 1'b1;
      claim_v = ($urandom_range(0, 1) == 0);
      claim_idx_v = ($urandom_range(0, 2) == 0) ? 6'($urandom_range(0, 40)) : pick(m_pend);
      comp_v = ($urandom_range(0, 1) == 0);
      comp_idx_v = ($urandom_range(0, 2) == 0) ? 6'($urandom_range(0, 40)) : pick(m_busy);
      tick();
      check("rand", irq_pending_o, m_pend);
    end
    idle_strobes();

`ifdef PLIC_EDGE_TRIG_EN
    // Edge source 2: five extra edges saturate the counter at three re-pends.
    do_reset();
    edge_v = 32'h4;
    pulse2();
    check("edge_pend", {31'b0, irq_pending_o[2]}, 32'h1);
    claim_v = 1'b1; claim_idx_v = 6'd3;
    tick();
    idle_strobes();
    repeat (5) pulse2();
    check("edge_insvc", {31'b0, irq_pending_o[2]}, 32'h0);
    for (int r = 0; r < 3; r++) begin
      comp_v = 1'b1; comp_idx_v = 6'd3;
      tick();
      idle_strobes();
      check("edge_repend", {31'b0, irq_pending_o[2]}, 32'h1);
      claim_v = 1'b1; claim_idx_v = 6'd3;
      tick();
      idle_strobes();
    end
    comp_v = 1'b1; comp_idx_v = 6'd3;
    tick();
    idle_strobes();
    tick();
    check("edge_final_idle", {31'b0, irq_pending_o[2]}, 32'h0);
    edge_v = '0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
